// File: rtl/reg_file_param.sv
// ---------------------------------------------------------------------------
// reg_file_param
// Parameterised register file: two registered read ports (A, B), one write
// port (D). After reset a CLEAR sequence zeroes every register, one per
// falling clock edge, before o_ready rises and normal operation (RUN) begins.
// All state changes happen on the falling edge of I_clk; reset is
// synchronous and active-low.
//
// Build option:
//   REG_FILE_BYPASS_EN  - when defined, a read that selects the register
//                         being written on the same edge captures the new
//                         write data (write-to-read forwarding). When not
//                         defined, the read captures the pre-write value.
// ---------------------------------------------------------------------------
module reg_file_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic              I_en,
    input  logic              I_we,
    input  logic [ADDR_W-1:0] I_selA,
    input  logic [ADDR_W-1:0] I_selB,
    input  logic [ADDR_W-1:0] I_selD,
    input  logic [DATA_W-1:0] I_dataD,
    output logic [DATA_W-1:0] o_dataA,
    output logic [DATA_W-1:0] o_dataB,
    output logic              o_ready
);

    localparam int DEPTH = 2 ** ADDR_W;

    // FSM encoding
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    // Index of the last register; reaching it ends the clear sequence
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(1);

    // State
    logic [0:0]        state_q,   state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0] data_a_q,  data_a_d;
    logic [DATA_W-1:0] data_b_q,  data_b_d;
    logic              ready_q,   ready_d;
    logic [DATA_W-1:0] regs_q [DEPTH];

    // Single shared write path (used by the clear sequence and by RUN writes)
    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [DATA_W-1:0] wr_data_s;

    // A user write that will really land in the array this edge
    logic              run_wr_s;
    // Per-port forwarding select
    logic              fwd_a_s;
    logic              fwd_b_s;

    // True when the select addresses the hardwired-zero register
    function automatic logic is_zero_sel(input logic [ADDR_W-1:0] sel);
        return (ZERO_REG != 0) && (sel == '0);
    endfunction

    // Value one read port captures: zero register, forwarded data, or storage
    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] sel,
        input logic              fwd,
        input logic [DATA_W-1:0] fwd_data,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] val;
        if (is_zero_sel(sel)) begin
            val = '0;
        end else if (fwd) begin
            val = fwd_data;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    // Writes to the zero register are discarded when it is hardwired
    assign run_wr_s = I_en && I_we && !is_zero_sel(I_selD);

`ifdef REG_FILE_BYPASS_EN
    assign fwd_a_s = run_wr_s && (I_selA == I_selD);
    assign fwd_b_s = run_wr_s && (I_selB == I_selD);
`else
    assign fwd_a_s = 1'b0;
    assign fwd_b_s = 1'b0;
`endif

    // FSM next state, clear counter and write-path selection
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ready_d   = ready_q;
        wr_en_s   = 1'b0;
        wr_addr_s = clr_cnt_q;
        wr_data_s = '0;
        case (state_q)
            ST_CLEAR: begin
                // Inputs are ignored; zero the register under the counter
                wr_en_s   = 1'b1;
                wr_addr_s = clr_cnt_q;
                wr_data_s = '0;
                if (clr_cnt_q == LAST_IDX) begin
                    // Last register cleared: enter RUN on this same edge
                    state_d   = ST_RUN;
                    ready_d   = 1'b1;
                    clr_cnt_d = clr_cnt_q;
                end else begin
                    state_d   = ST_CLEAR;
                    ready_d   = 1'b0;
                    clr_cnt_d = clr_cnt_q + ONE_IDX;
                end
            end
            ST_RUN: begin
                // RUN is left only through reset
                state_d = ST_RUN;
                ready_d = 1'b1;
                if (run_wr_s) begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = I_selD;
                    wr_data_s = I_dataD;
                end else begin
                    wr_en_s   = 1'b0;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
                ready_d   = 1'b0;
            end
        endcase
    end

    // Read-port next values: zero in CLEAR, sample when enabled in RUN, else hold
    always_comb begin
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        case (state_q)
            ST_CLEAR: begin
                data_a_d = '0;
                data_b_d = '0;
            end
            ST_RUN: begin
                if (I_en) begin
                    data_a_d = read_port(I_selA, fwd_a_s, I_dataD, regs_q[I_selA]);
                    data_b_d = read_port(I_selB, fwd_b_s, I_dataD, regs_q[I_selB]);
                end else begin
                    data_a_d = data_a_q;
                    data_b_d = data_b_q;
                end
            end
            default: begin
                data_a_d = '0;
                data_b_d = '0;
            end
        endcase
    end

    // Control and output registers with synchronous active-low reset
    always_ff @(negedge I_clk) begin
        if (!I_rst_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            data_a_q  <= '0;
            data_b_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            data_a_q  <= data_a_d;
            data_b_q  <= data_b_d;
            ready_q   <= ready_d;
        end
    end

    // Storage array; no reset of its own, the clear sequence defines contents.
    // A write presented together with reset is dropped.
    always_ff @(negedge I_clk) begin
        if (I_rst_n && wr_en_s) begin
            regs_q[wr_addr_s] <= wr_data_s;
        end
    end

    assign o_dataA = data_a_q;
    assign o_dataB = data_b_q;
    assign o_ready = ready_q;

endmodule
